dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS core. It drives the tuning word `phase_M`, amplitude `signal_A` and waveform select `signal_shape` into the phase accumulator / waveform LUT path. It steps `phase_M` from a start to a stop frequency with a programmable dwell, either one-shot or as a continuous up/down (triangle) sweep. Every tuning-word change after the initial load is committed only on a phase-accumulator wrap pulse, so the output waveform stays glitch-free.

## Interface
Parameters:
- `M_W`, 13: tuning-word width.
- `A_W`, 11: amplitude width.
- `DWELL_W`, 16: dwell counter width.

Ports:
- Reset is `rst`, synchronous, active-high; the clock is `clk`.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `start`, in, 1: one-cycle request; latches the config and begins the sweep.
- `stop`, in, 1: one-cycle abort.
- `f_start`, in, M_W: first tuning word.
- `f_stop`, in, M_W: endpoint tuning word.
- `f_step`, in, M_W: step magnitude (unsigned).
- `dwell`, in, DWELL_W: cycles spent in RUN per step; 0 is treated as 1.
- `mode`, in, 1: 0 = one-shot, 1 = continuous triangle.
- `amp_in`, in, A_W: amplitude applied at start.
- `shape_in`, in, 2: 0 = sin, 1 = triangle, 2 = square.
- `acc_wrap`, in, 1: one-cycle pulse from the phase accumulator on overflow.
- `phase_M`, out, M_W: tuning word to the accumulator.
- `signal_A`, out, A_W: amplitude.
- `signal_shape`, out, 2: waveform select.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse on one-shot completion.

## Operation
- States:
  - IDLE
  - RUN: dwell counting.
  - WAIT_WRAP: next value computed, awaiting `acc_wrap`.
- All inputs except `start`/`stop`/`acc_wrap` are sampled only on an accepted `start`. They are latched as `lo = f_start`, `hi = f_stop`, plus step, dwell, mode. Later input changes are ignored until the next start.
- IDLE + `start`:
  - `phase_M <= f_start`, `signal_A <= amp_in`, `signal_shape <= shape_in`, written immediately with no wrap wait.
  - Target = `f_stop`; direction is up if `f_stop >= f_start`, else down.
  - Degenerate case (`f_step == 0` or `f_start == f_stop`): assert `done`, stay in IDLE (fixed tone). This applies in either mode.
  - Otherwise go to RUN with the dwell counter cleared.
- RUN: counter increments each cycle. After exactly `max(dwell,1)` cycles in RUN, compute next and go to WAIT_WRAP. `acc_wrap` is ignored while in RUN.
- Next-value arithmetic uses M_W+1 bits, with no modular wrap:
  - Up: `next = min(phase_M + f_step, target)`.
  - Down: `next = (phase_M < f_step) ? target : max(phase_M - f_step, target)`.
- WAIT_WRAP + `acc_wrap`: `phase_M <= next`. Then:
  - If `next != target`, go to RUN.
  - If `next == target` and mode 0: pulse `done`, go to IDLE.
  - If `next == target` and mode 1: target toggles to the other latched endpoint, direction reverses, go to RUN.
- `stop` in RUN or WAIT_WRAP: go to IDLE next edge. Outputs hold their current values, no `done`, and a pending next is discarded. `stop` in IDLE has no effect.
- `start` while busy is ignored.
- Priority within one cycle: `rst` > `stop` > `acc_wrap` > `start`.
- `signal_A`/`signal_shape` change only on an accepted start.

## Timing
- Reset values:
  - `phase_M = 0`, `signal_A = 0`, `signal_shape = 0`, `busy = 0`, `done = 0`.
  - State IDLE, counters 0.
- `rst` mid-sweep aborts on that edge.
- Start latency: `start` sampled high at edge T; new outputs and `busy` are visible after T.
- Step period with `acc_wrap` tied high: `max(dwell,1)` RUN cycles + 1 WAIT_WRAP cycle.
- The commit occurs on the edge where `acc_wrap` = 1 is sampled in WAIT_WRAP. `done` is registered on the same edge, so it is high in the same cycle as the final `phase_M` value, for one cycle. `busy` falls on that edge.
- WAIT_WRAP has no timeout; it waits indefinitely for `acc_wrap`.

## Test plan
- Reset during an active sweep: all outputs 0 and `busy = 0` the cycle after the `rst` edge.
- Up sweep `f_start = 10`, `f_stop = 40`, `f_step = 10`, `dwell = 4`, mode 0, `acc_wrap = 1`: `phase_M` goes 10, 20, 30, 40, each value changing 5 cycles apart; `done` pulses once with 40; `busy` drops.
- Down with clamp `f_start = 100`, `f_stop = 75`, `f_step = 10`: `phase_M` goes 100, 90, 80, 75 and then `done`. Overflow guard `f_start = 8180`, `f_stop = 8191`, `f_step = 20`: `phase_M` goes 8180, 8191, with no wrap to a small value.
- Triangle mode 1 `f_start = 10`, `f_stop = 30`, `f_step = 10`: `phase_M` goes 10, 20, 30, 20, 10, 20, …; `done` is never asserted. `stop` mid-run: IDLE, `phase_M` holds its value; a new `start` is accepted afterwards.
- Wrap gating: hold `acc_wrap = 0` for 50 cycles in WAIT_WRAP and `phase_M` stays unchanged; a single pulse commits the value on that edge. `stop` and `acc_wrap` in the same cycle: no commit, IDLE.
- Degenerate: `f_step = 0`, `f_start = 500`: `phase_M = 500` and `done` pulse after the start edge, `busy` stays 0. `start` while busy is ignored. `dwell = 0` behaves as `dwell = 1`.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Bundle of control, configuration and status signals between a sweep
// requester (master) and the DDS sweep scheduler (slave).
interface dds_sweep_ctrl_if #(
    parameter int M_W     = 13,
    parameter int A_W     = 11,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic [M_W-1:0]     f_start;
    logic [M_W-1:0]     f_stop;
    logic [M_W-1:0]     f_step;
    logic [DWELL_W-1:0] dwell;
    logic               mode;
    logic [A_W-1:0]     amp_in;
    logic [1:0]         shape_in;
    logic               acc_wrap;
    logic [M_W-1:0]     phase_M;
    logic [A_W-1:0]     signal_A;
    logic [1:0]         signal_shape;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, f_start, f_stop, f_step, dwell, mode,
               amp_in, shape_in, acc_wrap,
        input  phase_M, signal_A, signal_shape, busy, done
    );

    modport slave (
        input  start, stop, f_start, f_stop, f_step, dwell, mode,
               amp_in, shape_in, acc_wrap,
        output phase_M, signal_A, signal_shape, busy, done
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler for the DDS core. Steps the tuning word from a
// start to a stop frequency with a programmable dwell, one-shot or as a
// continuous triangle sweep. Tuning-word changes after the initial load are
// committed only on a phase-accumulator wrap pulse to keep the output glitch-free.
module dds_sweep_ctrl #(
    parameter int M_W     = 13,
    parameter int A_W     = 11,
    parameter int DWELL_W = 16
) (
    input logic            clk,
    input logic            rst,
    dds_sweep_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_WRAP
    } state_t;

    state_t             state;
    logic [M_W-1:0]     lo;
    logic [M_W-1:0]     hi;
    logic [M_W-1:0]     step;
    logic [M_W-1:0]     target;
    logic [M_W-1:0]     next_val;
    logic [DWELL_W-1:0] dwell_lat;
    logic [DWELL_W-1:0] cnt;
    logic               mode_lat;
    logic               dir_up;

    logic [DWELL_W-1:0] dwell_eff;
    logic [M_W:0]       sum_up;
    logic [M_W:0]       diff_dn;
    logic [M_W-1:0]     next_calc;

    // A dwell of zero is treated as a single RUN cycle
    always_comb begin
        dwell_eff = (dwell_lat == '0) ? DWELL_W'(1) : dwell_lat;
    end

    // Next tuning word, clamped to the target with one extra bit so nothing wraps
    always_comb begin
        sum_up  = {1'b0, bus.phase_M} + {1'b0, step};
        diff_dn = {1'b0, bus.phase_M} - {1'b0, step};
        if (dir_up) begin
            next_calc = (sum_up > {1'b0, target}) ? target : sum_up[M_W-1:0];
        end else if (bus.phase_M < step) begin
            next_calc = target;
        end else begin
            next_calc = (diff_dn < {1'b0, target}) ? target : diff_dn[M_W-1:0];
        end
    end

    // Sweep state machine with registered outputs and latched configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            lo               <= '0;
            hi               <= '0;
            step             <= '0;
            target           <= '0;
            next_val         <= '0;
            dwell_lat        <= '0;
            cnt              <= '0;
            mode_lat         <= 1'b0;
            dir_up           <= 1'b0;
            bus.phase_M      <= '0;
            bus.signal_A     <= '0;
            bus.signal_shape <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lo               <= bus.f_start;
                        hi               <= bus.f_stop;
                        step             <= bus.f_step;
                        dwell_lat        <= bus.dwell;
                        mode_lat         <= bus.mode;
                        target           <= bus.f_stop;
                        dir_up           <= (bus.f_stop >= bus.f_start);
                        cnt              <= '0;
                        bus.phase_M      <= bus.f_start;
                        bus.signal_A     <= bus.amp_in;
                        bus.signal_shape <= bus.shape_in;
                        if ((bus.f_step == '0) || (bus.f_start == bus.f_stop)) begin
                            bus.done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt == dwell_eff - 1'b1) begin
                        next_val <= next_calc;
                        cnt      <= '0;
                        state    <= WAIT_WRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_WRAP: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (bus.acc_wrap) begin
                        bus.phase_M <= next_val;
                        cnt         <= '0;
                        if (next_val != target) begin
                            state <= RUN;
                        end else if (!mode_lat) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            target <= (target == hi) ? lo : hi;
                            dir_up <= ~dir_up;
                            state  <= RUN;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Testbench for dds_sweep_ctrl: directed sweeps plus randomized sweeps,
// checked every cycle against a transaction-level reference model.
module tb_dds_sweep_ctrl;
    localparam int M_W     = 13;
    localparam int A_W     = 11;
    localparam int DWELL_W = 16;

    logic clk = 1'b0;
    logic rst;

    dds_sweep_ctrl_if #(.M_W(M_W), .A_W(A_W), .DWELL_W(DWELL_W)) bus ();

    dds_sweep_ctrl #(.M_W(M_W), .A_W(A_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: what the outputs should be and where the sweep is
    int m_phase, m_amp, m_shape;
    int m_busy, m_done;
    int m_lo, m_hi, m_tgt, m_step, m_dwell, m_mode, m_since;
    bit m_up;

    int wrap_mode = 0;   // 0: wrap always high, 1: random wrap, other: manual
    int seen[$];
    int last_phase;
    int done_cnt;

    function automatic int next_of(int cur, int tgt, bit up, int stp);
        int n;
        if (up) begin
            n = cur + stp;
            if (n > tgt) n = tgt;
        end else begin
            n = cur - stp;
            if (n < tgt) n = tgt;
        end
        return n;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_phase = 0; m_amp = 0; m_shape = 0;
            m_busy = 0; m_done = 0; m_since = 0;
            return;
        end
        m_done = 0;
        if (m_busy != 0) begin
            m_since++;
            if (bus.stop) begin
                m_busy = 0;
            end else if (bus.acc_wrap && m_since > m_dwell) begin
                m_phase = next_of(m_phase, m_tgt, m_up, m_step);
                m_since = 0;
                if (m_phase == m_tgt) begin
                    if (m_mode == 0) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_tgt = (m_tgt == m_hi) ? m_lo : m_hi;
                        m_up  = !m_up;
                    end
                end
            end
        end else if (bus.start) begin
            m_lo    = int'(bus.f_start);
            m_hi    = int'(bus.f_stop);
            m_step  = int'(bus.f_step);
            m_dwell = (bus.dwell == '0) ? 1 : int'(bus.dwell);
            m_mode  = int'(bus.mode);
            m_phase = m_lo;
            m_amp   = int'(bus.amp_in);
            m_shape = int'(bus.shape_in);
            m_tgt   = m_hi;
            m_up    = (m_hi >= m_lo);
            m_since = 0;
            if (m_step == 0 || m_lo == m_hi) m_done = 1;
            else m_busy = 1;
        end
    endtask

    task automatic checkOutput(string tag, logic [31:0] got, int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic checkModel();
        checkOutput("phase_M",      32'(bus.phase_M),      m_phase);
        checkOutput("signal_A",     32'(bus.signal_A),     m_amp);
        checkOutput("signal_shape", 32'(bus.signal_shape), m_shape);
        checkOutput("busy",         32'(bus.busy),         m_busy);
        checkOutput("done",         32'(bus.done),         m_done);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        checkModel();
        if (bus.done === 1'b1) done_cnt++;
        if (int'(bus.phase_M) != last_phase) begin
            last_phase = int'(bus.phase_M);
            seen.push_back(last_phase);
        end
        if (wrap_mode == 0) bus.acc_wrap = 1'b1;
        else if (wrap_mode == 1) bus.acc_wrap = ($urandom_range(0, 99) < 40);
    endtask

    task automatic applyStimulus(int fs, int ft, int st, int dw, int md, int amp, int shp);
        bus.f_start  = M_W'(fs);
        bus.f_stop   = M_W'(ft);
        bus.f_step   = M_W'(st);
        bus.dwell    = DWELL_W'(dw);
        bus.mode     = 1'(md);
        bus.amp_in   = A_W'(amp);
        bus.shape_in = 2'(shp);
        bus.start    = 1'b1;
        done_cnt     = 0;
        tick();
        bus.start = 1'b0;
        seen.delete();
        last_phase = int'(bus.phase_M);
        seen.push_back(last_phase);
    endtask

    task automatic run_until_idle(int max_cyc);
        for (int i = 0; i < max_cyc && bus.busy === 1'b1; i++) tick();
        checkOutput("idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic checkList(string tag, int exp[$], bit exact);
        if (exact) checkOutput({tag, "_len"}, 32'(seen.size()), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            checkOutput(tag, (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF, exp[i]);
        end
    endtask

    initial begin
        int exp_q[$];
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.acc_wrap = 1'b0;
        bus.f_start = '0; bus.f_stop = '0; bus.f_step = '0; bus.dwell = '0;
        bus.mode = 1'b0; bus.amp_in = '0; bus.shape_in = '0;
        last_phase = 0; done_cnt = 0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        tick();

        // One-shot up sweep
        wrap_mode = 0;
        applyStimulus(10, 40, 10, 4, 0, 300, 1);
        run_until_idle(200);
        exp_q = {10, 20, 30, 40};
        checkList("up_seq", exp_q, 1);
        checkOutput("up_done_cnt", 32'(done_cnt), 1);

        // Down sweep with clamp at the endpoint
        applyStimulus(100, 75, 10, 2, 0, 7, 2);
        run_until_idle(200);
        exp_q = {100, 90, 80, 75};
        checkList("down_seq", exp_q, 1);

        // Top-of-range overflow guard
        applyStimulus(8180, 8191, 20, 1, 0, 2047, 0);
        run_until_idle(200);
        exp_q = {8180, 8191};
        checkList("ovf_seq", exp_q, 1);

        // Continuous triangle, then abort and restart
        applyStimulus(10, 30, 10, 1, 1, 55, 1);
        repeat (40) tick();
        exp_q = {10, 20, 30, 20, 10, 20, 30};
        checkList("tri_seq", exp_q, 0);
        checkOutput("tri_done_cnt", 32'(done_cnt), 0);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        tick();
        applyStimulus(0, 30, 10, 0, 0, 9, 3);
        run_until_idle(200);
        exp_q = {0, 10, 20, 30};
        checkList("dwell0_seq", exp_q, 1);

        // Wrap gating: no commit until the pulse; stop beats a simultaneous wrap
        wrap_mode = 2;
        bus.acc_wrap = 1'b0;
        applyStimulus(1000, 1100, 50, 1, 0, 3, 0);
        repeat (51) tick();
        checkOutput("hold_phase", 32'(bus.phase_M), 1000);
        bus.acc_wrap = 1'b1; tick(); bus.acc_wrap = 1'b0;
        checkOutput("commit_phase", 32'(bus.phase_M), 1050);
        tick(); tick();
        bus.stop = 1'b1; bus.acc_wrap = 1'b1;
        tick();
        bus.stop = 1'b0; bus.acc_wrap = 1'b0;
        checkOutput("stop_wrap_phase", 32'(bus.phase_M), 1050);
        checkOutput("stop_wrap_busy", 32'(bus.busy), 0);
        tick();

        // Degenerate start: fixed tone, done pulse, never busy
        wrap_mode = 0;
        applyStimulus(500, 900, 0, 3, 1, 11, 2);
        checkOutput("degen_phase", 32'(bus.phase_M), 500);
        checkOutput("degen_done", 32'(bus.done), 1);
        checkOutput("degen_busy", 32'(bus.busy), 0);
        tick();

        // Start while busy is ignored
        applyStimulus(10, 40, 10, 4, 0, 21, 1);
        tick(); tick();
        bus.f_start = M_W'(3000); bus.f_stop = M_W'(10); bus.f_step = M_W'(1);
        bus.amp_in = A_W'(999); bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_until_idle(200);
        exp_q = {10, 20, 30, 40};
        checkList("busy_start_seq", exp_q, 1);

        // Reset in the middle of a sweep
        applyStimulus(0, 5000, 100, 2, 1, 77, 3);
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checkOutput("rst_phase", 32'(bus.phase_M), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        tick();

        // Randomized sweeps with random wrap timing, stray starts/stops and config churn
        for (int it = 0; it < 40; it++) begin
            int fs, ft, st, diff, dw, md, budget;
            fs = $urandom_range(0, 8191);
            ft = ($urandom_range(0, 5) == 0) ? fs : int'($urandom_range(0, 8191));
            diff = (fs > ft) ? fs - ft : ft - fs;
            if ($urandom_range(0, 7) == 0) st = 0;
            else begin
                st = $urandom_range(diff / 10 + 1, diff + 50);
                if (st > 8191) st = 8191;
            end
            dw = $urandom_range(0, 5);
            md = $urandom_range(0, 1);
            wrap_mode = $urandom_range(0, 1);
            applyStimulus(fs, ft, st, dw, md, $urandom_range(0, 2047), $urandom_range(0, 3));
            budget = (md != 0) ? int'($urandom_range(30, 120)) : 3000;
            for (int c = 0; c < budget && bus.busy === 1'b1; c++) begin
                bus.f_start  = M_W'($urandom_range(0, 8191));
                bus.f_stop   = M_W'($urandom_range(0, 8191));
                bus.f_step   = M_W'($urandom_range(0, 8191));
                bus.dwell    = DWELL_W'($urandom_range(0, 9));
                bus.amp_in   = A_W'($urandom_range(0, 2047));
                bus.shape_in = 2'($urandom_range(0, 3));
                bus.start    = ($urandom_range(0, 49) == 0);
                bus.stop     = ($urandom_range(0, 199) == 0);
                tick();
            end
            bus.start = 1'b0;
            bus.stop  = 1'b0;
            if (md != 0) begin
                bus.stop = 1'b1; tick(); bus.stop = 1'b0;
            end
            checkOutput("rand_idle", 32'(bus.busy), 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
